// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Capacity (outstanding fetches + buffered instructions) is 2 when IF_PREFETCH_EN is defined, else 1.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN
  } if_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

`ifdef IF_PREFETCH_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  // Wide enough to count 0..CAPACITY.
  localparam int CNT_W = 2;

endpackage

// File: rtl/if_buffer.sv
// Tagged instruction FIFO (depth 1 or 2) plus the in-order address tag queue of granted fetches.
// A flush empties both; the head entry is presented to decode through a valid/ready port.
module if_buffer
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = CAPACITY
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_tag_push,
  input  logic [ADDR_W-1:0]  i_tag_addr,
  input  logic               i_rsp_valid,
  input  logic [INSTR_W-1:0] i_rsp_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [CNT_W-1:0]   o_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t            r_ent [DEPTH];
  logic [ADDR_W-1:0] r_tag [DEPTH];
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_tag_cnt;

  logic             w_pop;
  logic [CNT_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_tag_idx;

  assign w_pop     = o_valid && i_ready;
  assign w_wr_idx  = r_cnt - CNT_W'(w_pop);
  assign w_tag_idx = r_tag_cnt - CNT_W'(i_rsp_valid);

  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;
  assign o_instr = o_valid ? r_ent[0].instr : NOP_INSTR;
  assign o_pc    = o_valid ? r_ent[0].pc : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_cnt     <= '0;
      r_tag_cnt <= '0;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(i_rsp_valid) - CNT_W'(w_pop);
      r_tag_cnt <= r_tag_cnt + CNT_W'(i_tag_push) - CNT_W'(i_rsp_valid);
    end
  end

  // NOTE: payload storage carries no reset; the counters alone define validity and the outputs are masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_ent[i] <= r_ent[i+1];
    end
    if (i_rsp_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(w_wr_idx)) r_ent[i] <= '{instr: i_rsp_data, pc: r_tag[0]};
      end
      for (int i = 0; i < DEPTH - 1; i++) r_tag[i] <= r_tag[i+1];
    end
    if (i_tag_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(w_tag_idx)) r_tag[i] <= i_tag_addr;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the PC register, issues in-order memory fetches and hands
// tagged instructions to decode; a redirect discards all in-flight work. Prefetch via IF_PREFETCH_EN.
module if_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADDR_W-1:0]  i_pc_cur,
  output logic               o_pc_enable,
  output logic [ADDR_W-1:0]  o_pc_input,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_id_valid,
  input  logic               i_id_ready,
  output logic [INSTR_W-1:0] o_id_instr,
  output logic [ADDR_W-1:0]  o_id_pc
);

  if_state_e        r_state;
  logic [CNT_W-1:0] r_outstanding;

  logic [CNT_W-1:0] w_buf_count;
  logic [CNT_W-1:0] w_outstanding_nxt;
  logic             w_handshake;
  logic             w_slot_free;
  logic             w_grant;
  logic             w_rsp;
  logic             w_capture;

  assign w_handshake = o_id_valid && i_id_ready;
  assign w_slot_free = ((r_outstanding + w_buf_count) < CNT_W'(CAPACITY)) || w_handshake;

  assign o_imem_req  = !i_rst && (r_state == FETCH) && !i_redirect_valid && w_slot_free;
  assign o_imem_addr = i_pc_cur;
  assign w_grant     = o_imem_req && i_imem_gnt;

  // Responses seen in DRAIN or in a redirect cycle belong to the discarded stream.
  assign w_rsp     = i_imem_rvalid && (r_outstanding != '0);
  assign w_capture = w_rsp && (r_state != DRAIN) && !i_redirect_valid;

  assign w_outstanding_nxt = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp);

  assign o_pc_enable = !i_rst && (i_redirect_valid || w_grant);

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_pc_input = i_pc_cur + ADDR_W'(PC_STEP);
    if (i_rst) begin
      o_pc_input = RESET_PC;
    end else if (i_redirect_valid) begin
      o_pc_input = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  // In DRAIN the outstanding counter doubles as the drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (i_redirect_valid) begin
        r_state <= (w_outstanding_nxt != '0) ? DRAIN : FETCH;
      end else begin
        case (r_state)
          IDLE:        r_state <= FETCH;
          FETCH, WAIT: r_state <= (w_outstanding_nxt == CNT_W'(CAPACITY)) ? WAIT : FETCH;
          DRAIN:       if (w_outstanding_nxt == '0) r_state <= FETCH;
          default:     r_state <= IDLE;
        endcase
      end
    end
  end

  if_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (CAPACITY)
  ) u_buffer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_redirect_valid),
    .i_tag_push  (w_grant),
    .i_tag_addr  (i_pc_cur),
    .i_rsp_valid (w_capture),
    .i_rsp_data  (i_imem_rdata),
    .o_valid     (o_id_valid),
    .i_ready     (i_id_ready),
    .o_instr     (o_id_instr),
    .o_pc        (o_id_pc),
    .o_count     (w_buf_count)
  );

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage sitting between the program-counter register and the decode stage. Each cycle it reads the current PC, issues word fetches to instruction memory over a request/grant plus response-valid handshake, and drives the PC register's `pc_enable`/`pc_input` with PC+4 or a redirect target. It presents fetched instructions to decode through a valid/ready output register. All in-flight work is discarded on a branch/jump redirect.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 32'h0000_0000: value driven on `pc_input` while in reset.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pc_cur`  in  ADDR_W: current PC, from the PC register output.
- `pc_enable`  out  1: PC register load enable.
- `pc_input`  out  ADDR_W: next-PC value for the PC register.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  ADDR_W: fetch address, always equal to `pc_cur`.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: response valid, in order, at least 1 cycle after grant.
- `imem_rdata`  in  32: instruction word.
- `redirect_valid`  in  1: branch/jump taken.
- `redirect_pc`  in  ADDR_W: redirect target.
- `id_valid`  out  1: instruction available to decode.
- `id_ready`  in  1: decode accepts.
- `id_instr`  out  32: instruction.
- `id_pc`  out  ADDR_W: address of `id_instr`.

## Operation
- Reset values:
  - `imem_req`=0, `pc_enable`=0, `pc_input`=RESET_PC.
  - `id_valid`=0, `id_instr`=0, `id_pc`=0.
  - Outstanding count = 0; state IDLE.
- States and transitions:
  - IDLE: entered from reset. Moves to FETCH after 1 cycle.
  - FETCH: `imem_req`=1 when a slot is free. A slot is free when (outstanding + buffered) < capacity, or an `id_valid && id_ready` handshake occurs this cycle.
  - On grant: `pc_enable`=1, `pc_input`=`pc_cur`+4 modulo 2^ADDR_W (wrap 0xFFFF_FFFC → 0). The granted address is pushed to an in-order address tag queue.
  - WAIT: entered when outstanding == capacity. Returns to FETCH on a response that frees a slot.
  - DRAIN: entered after a redirect while responses are still outstanding. Each `imem_rvalid` decrements the drop counter and is discarded. Returns to FETCH when the drop counter reaches 0.
- Response capture:
  - `imem_rvalid` writes `imem_rdata` and the oldest tag into the output buffer.
  - `id_valid` rises the following cycle.
  - Output fields are held stable while `id_valid && !id_ready`.
- Redirect (highest priority):
  - Same cycle: `pc_enable`=1, `pc_input`={`redirect_pc`[ADDR_W-1:2], 2'b00}, `imem_req`=0.
  - Next cycle: buffer emptied, `id_valid`=0, drop counter = outstanding count.
- Simultaneous events:
  - Redirect with `imem_rvalid`: the response is dropped.
  - Redirect with `id_valid && id_ready`: the handshake completes (decode keeps the instruction), then the buffer is flushed.
  - Redirect with `imem_gnt`: cannot occur, because `imem_req`=0 during a redirect.
  - `rst` overrides everything, including mid-DRAIN. The team guarantees memory responses are squashed externally on reset.

## Timing
- Grant to `id_valid`: `imem_rvalid` latency + 1 cycle.
- With 1-cycle memory and `id_ready`=1: sustained throughput is 1 instruction per 2 cycles (1 per cycle with prefetch).
- Redirect: first new request in cycle R+1 if nothing is outstanding; `id_valid` low in R+1.
- `pc_enable` is asserted only in grant or redirect cycles.

## Configuration
- `IF_PREFETCH_EN` defined:
  - Capacity 2: 2-entry output FIFO and up to 2 outstanding requests.
  - A fetch may be issued while decode stalls.
- Not defined:
  - Capacity 1: single output register and at most 1 outstanding request.
  - A new request is issued only once the register is empty or being drained this cycle.

## Structure
- Shared package `if_pkg`: state enum (IDLE, FETCH, WAIT, DRAIN), `INSTR_W`=32, `PC_STEP`=4, NOP encoding 32'h0000_0000.
- Sub-module `if_buffer`: tagged instruction FIFO with depth 1 or 2 plus the address tag queue, flush input, valid/ready output.

## Test plan
- Reset then `id_ready`=1, 1-cycle memory, `pc_cur` starting at 0 → grants at 0, 4, 8, and `id_pc` sequence 0, 4, 8 with matching `id_instr`.
- Decode stalls 5 cycles holding `id_instr`=32'h2002_0005 → outputs stable, no more than capacity outstanding, no PC advance beyond capacity.
- Redirect to 0x0000_0103 while 1 fetch is outstanding → `pc_input`=0x0000_0100 in the same cycle, late response dropped, next `id_pc`=0x100.
- Redirect in the same cycle as an `id_valid && id_ready` handshake at `id_pc`=0x20 → 0x20 consumed, buffer flushed, no duplicate.
- `pc_cur`=0xFFFF_FFFC granted → `pc_input`=0x0000_0000.
- `rst` asserted during DRAIN → all outputs return to reset values the next cycle, fetch restarts from IDLE.
